// File: rtl/ram_port_pkg.sv
// Shared types and default sizes for the RAM port initiators.
package ram_port_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    // INIT exists only when the power-up clear is built in
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Client command as seen at the default sizes
    typedef struct packed {
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/ram_port_initiator_chk.sv
// Runtime properties of the RAM port initiator: credit bound and
// response hold under back-pressure.
module ram_port_initiator_chk #(
    parameter int RSP_DEPTH  = 2,
    parameter int CNT_W      = 2,
    parameter int DATA_WIDTH = 8
) (
    input logic                  clk_a,
    input logic                  rst_a,
    input logic [CNT_W-1:0]      used_cnt,
    input logic                  rsp_valid,
    input logic                  rsp_ready,
    input logic [DATA_WIDTH-1:0] rsp_rdata
);

    // Reads in flight plus buffered responses never exceed the buffer size
    a_credit_bound: assert property (@(posedge clk_a) disable iff (rst_a)
        used_cnt <= CNT_W'(RSP_DEPTH));

    // A stalled response stays valid with unchanged data
    a_rsp_hold: assert property (@(posedge clk_a) disable iff (rst_a)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata)));

endmodule

// File: rtl/ram_rsp_fifo.sv
// Small synchronous response FIFO with occupancy output.
// DEPTH must be a power of two so the pointers wrap naturally.
module ram_rsp_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_pop_s;
    logic             do_push_s;

    // A push into a full buffer is only taken when a pop frees the slot
    assign do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
    assign do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign empty    = (count_r == {CNT_W{1'b0}});
    assign full     = (count_r == CNT_W'(DEPTH));
    assign count    = count_r;

endmodule

// File: rtl/ram_port_initiator.sv
// Drives one port of the shared dual-port RAM for a single client.
// Commands issue one per cycle; read data returns in order through a
// credit-protected response buffer so nothing is lost under back-pressure.
// Optional power-up clear: define RAM_PORT_INITIATOR_CLEAR_EN.
module ram_port_initiator
    import ram_port_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_LAT     = 1,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk_a,
    input  logic                  rst_a,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  init_done
);

    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    logic                  init_done_r;
    logic                  run_next_s;
    logic                  accept_s;
    logic                  clr_we_s;
    logic [ADDR_WIDTH-1:0] clr_addr_s;
    logic                  ram_we_r;
    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic [DATA_WIDTH-1:0] ram_din_r;
    // Bit 0 marks the cycle a read address sits on the RAM pins; bit
    // RD_LAT marks the cycle its data is on ram_dout.
    logic [RD_LAT:0]       rd_pipe_r;
    logic [CNT_W-1:0]      inflight_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic [CNT_W-1:0]      used_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic                  fifo_pop_s;
    logic [DATA_WIDTH-1:0] fifo_rdata_s;

`ifdef RAM_PORT_INITIATOR_CLEAR_EN
    localparam int DEPTH = 1 << ADDR_WIDTH;

    state_e                state_r;
    state_e                state_next_s;
    logic [ADDR_WIDTH-1:0] clr_addr_r;
    logic [ADDR_WIDTH-1:0] clr_addr_next_s;

    // Clear-sequencer state and address counter
    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            state_r    <= ST_INIT;
            clr_addr_r <= '0;
        end else begin
            state_r    <= state_next_s;
            clr_addr_r <= clr_addr_next_s;
        end
    end

    // Walk every address writing zero, then hand over to normal operation
    always_comb begin
        state_next_s    = state_r;
        clr_addr_next_s = clr_addr_r;
        clr_we_s        = 1'b0;
        case (state_r)
            ST_INIT: begin
                clr_we_s        = 1'b1;
                clr_addr_next_s = clr_addr_r + ADDR_WIDTH'(1);
                if (clr_addr_r == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_next_s = ST_RUN;
            end
            default: begin
                state_next_s    = ST_INIT;
                clr_addr_next_s = '0;
            end
        endcase
    end

    assign clr_addr_s = clr_addr_r;
    assign run_next_s = (state_next_s == ST_RUN);
`else
    assign clr_we_s   = 1'b0;
    assign clr_addr_s = '0;
    assign run_next_s = 1'b1;
`endif

    // init_done is held low through reset and any clear sequence
    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            init_done_r <= 1'b0;
        end else begin
            init_done_r <= run_next_s;
        end
    end

    // Count reads still travelling through the RAM latency pipe
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            inflight_s = inflight_s + CNT_W'(rd_pipe_r[i]);
        end
    end

    // Writes are gated by credits too, so acceptance has a single rule
    assign used_s    = inflight_s + fifo_count_s;
    assign cmd_ready = init_done_r && (used_s < CNT_W'(RSP_DEPTH));
    assign accept_s  = cmd_valid && cmd_ready;

    // Register the RAM port: clear writes first, then accepted commands
    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            ram_we_r   <= 1'b0;
            ram_addr_r <= '0;
            ram_din_r  <= '0;
        end else if (clr_we_s) begin
            ram_we_r   <= 1'b1;
            ram_addr_r <= clr_addr_s;
            ram_din_r  <= '0;
        end else if (accept_s) begin
            ram_we_r   <= cmd_we;
            ram_addr_r <= cmd_addr;
            ram_din_r  <= cmd_wdata;
        end else begin
            ram_we_r   <= 1'b0;
        end
    end

    // Track each issued read until its data appears on ram_dout
    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            rd_pipe_r <= '0;
        end else begin
            rd_pipe_r <= {rd_pipe_r[RD_LAT-1:0], accept_s && !cmd_we};
        end
    end

    assign fifo_pop_s = !fifo_empty_s && rsp_ready;

    ram_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk_a),
        .rst       (rst_a),
        .push      (rd_pipe_r[RD_LAT]),
        .push_data (ram_dout),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_rdata_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

    ram_port_initiator_chk #(
        .RSP_DEPTH  (RSP_DEPTH),
        .CNT_W      (CNT_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .clk_a     (clk_a),
        .rst_a     (rst_a),
        .used_cnt  (used_s),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata)
    );

    assign ram_we    = ram_we_r;
    assign ram_addr  = ram_addr_r;
    assign ram_din   = ram_din_r;
    assign rsp_valid = !fifo_empty_s;
    assign rsp_rdata = fifo_rdata_s;
    assign init_done = init_done_r;

    // Full flag is implied by credits; kept for visibility only
    logic unused_s;
    assign unused_s = fifo_full_s;

endmodule
